pipe_skid_stage: RTL and testbench
==================================

Name: pipe_skid_stage

Overview:
- Parametrised, elastic successor to the fixed EX/MEM pipeline register.
- Carries the writeback bundle between the EX and MEM stages. The bundle is write data, destination register address, write enable and optional HI/LO results.
- Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure from MEM never creates a combinational ready path into EX.
- Adds flush for branch and exception squash, plus a saturating back-pressure cycle counter for performance analysis.

Parameters:
- DATA_W, 32: width of the write data and of each HI/LO word.
- ADDR_W, 5: width of the destination register address.
- HILO_EN, 1: 1 carries the HI/LO fields; 0 ties the out_hi, out_lo and out_whilo outputs to 0.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  squash all held entries; higher priority than any handshake.
- in_valid  in  1  EX presents a valid bundle.
- in_ready  out  1  stage can accept a bundle; registered.
- in_wdata  in  DATA_W  result data.
- in_wd  in  ADDR_W  destination register address.
- in_wreg  in  1  register-file write enable.
- in_whilo  in  1  HI/LO write enable.
- in_hi  in  DATA_W  HI result.
- in_lo  in  DATA_W  LO result.
- out_valid  out  1  MEM-side bundle is valid.
- out_ready  in  1  MEM accepts the bundle.
- out_wdata  out  DATA_W  result data toward MEM.
- out_wd  out  ADDR_W  destination register address toward MEM.
- out_wreg  out  1  write enable toward MEM; gated by out_valid.
- out_whilo  out  1  HI/LO write enable toward MEM; gated by out_valid.
- out_hi  out  DATA_W  HI result toward MEM.
- out_lo  out  DATA_W  LO result toward MEM.
- stall_cnt  out  CNT_W  number of cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State becomes EMPTY.
  - in_ready=1, out_valid=0.
  - All data outputs become 0: out_wd=0 (NOP address), out_wreg=0, out_whilo=0.
  - stall_cnt=0.
  - Reset overrides flush and all handshakes, including mid-transfer.
- Storage: main register M drives the outputs; skid register S holds one bundle.
- Transfer definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- States and transitions:
  - EMPTY (M and S empty):
    - accept → M ← input, go to ONE.
  - ONE (M full):
    - accept & drain → M ← input, stay in ONE.
    - accept & !drain → S ← input, go to TWO; in_ready=0 from the next cycle.
    - !accept & drain → go to EMPTY.
  - TWO (M and S full, in_ready=0):
    - drain → M ← S, go to ONE; in_ready=1 from the next cycle.
- Latency and ordering:
  - An accepted bundle appears on the outputs 1 cycle later when the stage was EMPTY or draining.
  - Full throughput: one bundle per cycle while out_ready=1.
  - Order is strictly FIFO; no bundle is dropped or duplicated.
- in_ready equals (state != TWO), taken from a register; it never depends combinationally on out_ready.
- Flush: flush=1 at an edge sets state EMPTY and out_valid=0, and zeroes the output data, out_wd, out_wreg and out_whilo.
- Flush with simultaneous accept: the incoming bundle is also discarded.
- Flush does not clear stall_cnt.
- Bubble outputs:
  - While out_valid=0, out_wreg and out_whilo must be 0, so MEM sees a NOP.
  - The data fields then hold their last value, or 0 after reset/flush.
- stall_cnt:
  - Increments by 1 on each edge where out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1; it does not wrap.
- HILO_EN=0: the HI/LO inputs are ignored, and out_hi, out_lo and out_whilo are constant 0.
- Data is captured unmodified; there is no width conversion and no arithmetic on the payload.

Test Plan:
- Reset with all inputs X except rst=1 → after 1 edge: out_valid=0, out_wd=0, out_wreg=0, in_ready=1, stall_cnt=0.
- Streaming: out_ready=1; push wdata 0x11,0x22,0x33 with wd 1,2,3 on consecutive cycles → the same values on the outputs one cycle later each, in order; in_ready stays 1.
- Back-pressure:
  - Push A=0xA, then hold out_ready=0 and push B=0xB → in_ready=0 after B.
  - A third push is refused while in_ready=0.
  - Raise out_ready → A then B drain in order.
  - stall_cnt equals the number of held cycles.
- Flush in TWO with in_valid=1 (C=0xC) at the same edge → next cycle out_valid=0, out_wreg=0, in_ready=1; A, B and C never appear.
- Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt=15.
- HILO: push in_whilo=1, hi=0xDEAD, lo=0xBEEF → outputs match with HILO_EN=1; with HILO_EN=0, out_hi=0, out_lo=0 and out_whilo=0.

Source files
------------

// File: rtl/pipe_skid_stage_if.sv
// pipe_skid_stage_if: EX -> MEM writeback channel through the elastic stage.
//
// Handshake: a bundle moves across a side on a rising clk edge where that
// side's valid and ready are both 1. A source holds valid and the payload
// stable until that edge. A sink's ready does not depend on valid.
//
// Signals:
//   flush             squash everything held in the stage (wins over handshakes)
//   in_valid/in_ready EX-side handshake; in_* carry the incoming bundle
//   out_valid/out_ready MEM-side handshake; out_* carry the outgoing bundle
// Modports:
//   slave  - the stage itself
//   master - the surrounding pipeline (EX producer, MEM consumer, control)
interface pipe_skid_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_wdata;
  logic [ADDR_W-1:0] in_wd;
  logic              in_wreg;
  logic              in_whilo;
  logic [DATA_W-1:0] in_hi;
  logic [DATA_W-1:0] in_lo;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_wdata;
  logic [ADDR_W-1:0] out_wd;
  logic              out_wreg;
  logic              out_whilo;
  logic [DATA_W-1:0] out_hi;
  logic [DATA_W-1:0] out_lo;

  modport slave (
    input  flush, in_valid, in_wdata, in_wd, in_wreg, in_whilo, in_hi, in_lo,
    input  out_ready,
    output in_ready,
    output out_valid, out_wdata, out_wd, out_wreg, out_whilo, out_hi, out_lo
  );

  modport master (
    output flush, in_valid, in_wdata, in_wd, in_wreg, in_whilo, in_hi, in_lo,
    output out_ready,
    input  in_ready,
    input  out_valid, out_wdata, out_wd, out_wreg, out_whilo, out_hi, out_lo
  );
endinterface

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: elastic EX/MEM pipeline register with a 2-entry skid buffer.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous, active-high reset
//   bus        pipe_skid_stage_if.slave: flush, EX-side in_* and MEM-side out_*
//   stall_cnt  saturating count of edges with out_valid=1 and out_ready=0
//   state_dbg  current FSM state (0 EMPTY, 1 ONE, 2 TWO)
//
// Register M drives the outputs; register S catches the one bundle EX may
// still push in the cycle MEM stalls, because in_ready is registered and
// cannot react to out_ready until the following cycle.
module pipe_skid_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int HILO_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_skid_stage_if.slave  bus,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } bundle_t;

  state_t  state;
  bundle_t m_q;
  bundle_t s_q;
  bundle_t in_b;
  logic    out_valid_q;
  logic    in_ready_q;
  logic    accept;
  logic    drain;

  assign in_b   = {bus.in_wdata, bus.in_wd, bus.in_wreg, bus.in_whilo,
                   bus.in_hi, bus.in_lo};
  assign accept = bus.in_valid & in_ready_q;
  assign drain  = out_valid_q & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      m_q         <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      stall_cnt   <= '0;
    end else begin
      // Performance counter keeps running through flushes.
      if (out_valid_q && !bus.out_ready && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end

      if (bus.flush) begin
        // Any bundle being accepted on this edge is discarded as well.
        state       <= EMPTY;
        m_q         <= '0;
        s_q         <= '0;
        out_valid_q <= 1'b0;
        in_ready_q  <= 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              m_q         <= in_b;
              out_valid_q <= 1'b1;
              state       <= ONE;
            end
          end
          ONE: begin
            if (accept && drain) begin
              m_q <= in_b;
            end else if (accept) begin
              s_q        <= in_b;
              in_ready_q <= 1'b0;
              state      <= TWO;
            end else if (drain) begin
              // Data fields keep their last value; enables are gated below.
              out_valid_q <= 1'b0;
              state       <= EMPTY;
            end
          end
          TWO: begin
            if (drain) begin
              m_q        <= s_q;
              in_ready_q <= 1'b1;
              state      <= ONE;
            end
          end
          default: begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign state_dbg     = state;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_wdata = m_q.wdata;
  assign bus.out_wd    = m_q.wd;
  // Enables are masked during bubbles so MEM always sees a NOP there.
  assign bus.out_wreg  = out_valid_q & m_q.wreg;

  generate
    if (HILO_EN != 0) begin : g_hilo
      assign bus.out_whilo = out_valid_q & m_q.whilo;
      assign bus.out_hi    = m_q.hi;
      assign bus.out_lo    = m_q.lo;
    end else begin : g_no_hilo
      assign bus.out_whilo = 1'b0;
      assign bus.out_hi    = '0;
      assign bus.out_lo    = '0;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int BW = 2 + AW + 3 * DW;

  typedef struct packed {
    logic [DW-1:0] wdata;
    logic [AW-1:0] wd;
    logic          wreg;
    logic          whilo;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
  } bun_t;

  typedef struct {
    logic          rst;
    logic          flush;
    logic          iv;
    logic [31:0]   wdata;
    logic [4:0]    wd;
    logic          ordy;
    logic          e_ov;
    logic          e_ir;
    logic [31:0]   e_wdata;
    logic [4:0]    e_wd;
    logic          e_wreg;
    int            e_cnt;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_skid_stage_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
  pipe_skid_stage_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();
  logic [15:0] cnt1;
  logic [3:0]  cnt2;
  logic [1:0]  st1;
  logic [1:0]  st2;

  pipe_skid_stage #(.DATA_W(DW), .ADDR_W(AW), .HILO_EN(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .stall_cnt(cnt1), .state_dbg(st1)
  );

  pipe_skid_stage #(.DATA_W(DW), .ADDR_W(AW), .HILO_EN(0), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .stall_cnt(cnt2), .state_dbg(st2)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  bun_t          last;
  int            mcnt;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive1(input logic flush, input logic iv, input bun_t b,
                        input logic ordy);
    bus1.flush     = flush;
    bus1.in_valid  = iv;
    bus1.in_wdata  = b.wdata;
    bus1.in_wd     = b.wd;
    bus1.in_wreg   = b.wreg;
    bus1.in_whilo  = b.whilo;
    bus1.in_hi     = b.hi;
    bus1.in_lo     = b.lo;
    bus1.out_ready = ordy;
  endtask

  task automatic drive2(input logic iv, input bun_t b, input logic ordy);
    bus2.flush     = 1'b0;
    bus2.in_valid  = iv;
    bus2.in_wdata  = b.wdata;
    bus2.in_wd     = b.wd;
    bus2.in_wreg   = b.wreg;
    bus2.in_whilo  = b.whilo;
    bus2.in_hi     = b.hi;
    bus2.in_lo     = b.lo;
    bus2.out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic r, logic f, logic iv, logic [31:0] wdata,
                              logic [4:0] wd, logic ordy, logic e_ov,
                              logic e_ir, logic [31:0] e_wdata,
                              logic [4:0] e_wd, logic e_wreg, int e_cnt);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.wdata = wdata; v.wd = wd;
    v.ordy = ordy; v.e_ov = e_ov; v.e_ir = e_ir; v.e_wdata = e_wdata;
    v.e_wd = e_wd; v.e_wreg = e_wreg; v.e_cnt = e_cnt;
    return v;
  endfunction

  vec_t tbl[19];

  initial begin
    bun_t b;
    bun_t zero_b;
    zero_b = '0;
    drive2(1'b0, zero_b, 1'b0);

    // rst, flush, iv, wdata, wd, out_ready | out_valid, in_ready, wdata, wd, wreg, stall_cnt
    tbl[0]  = mk(1, 'x, 'x, 'x,    'x, 'x, 0, 1, 0,     0,  0, 0);
    tbl[1]  = mk(0, 0, 1, 'h11,   1,  1,  1, 1, 'h11,  1,  1, 0);
    tbl[2]  = mk(0, 0, 1, 'h22,   2,  1,  1, 1, 'h22,  2,  1, 0);
    tbl[3]  = mk(0, 0, 1, 'h33,   3,  1,  1, 1, 'h33,  3,  1, 0);
    tbl[4]  = mk(0, 0, 0, 0,      0,  1,  0, 1, 'h33,  3,  0, 0);
    tbl[5]  = mk(0, 0, 1, 'hA,    10, 0,  1, 1, 'hA,   10, 1, 0);
    tbl[6]  = mk(0, 0, 1, 'hB,    11, 0,  1, 0, 'hA,   10, 1, 1);
    tbl[7]  = mk(0, 0, 1, 'hD,    13, 0,  1, 0, 'hA,   10, 1, 2);
    tbl[8]  = mk(0, 0, 1, 'hD,    13, 0,  1, 0, 'hA,   10, 1, 3);
    tbl[9]  = mk(0, 0, 0, 0,      0,  1,  1, 1, 'hB,   11, 1, 3);
    tbl[10] = mk(0, 0, 0, 0,      0,  1,  0, 1, 'hB,   11, 0, 3);
    tbl[11] = mk(0, 0, 1, 'hA,    10, 0,  1, 1, 'hA,   10, 1, 3);
    tbl[12] = mk(0, 0, 1, 'hB,    11, 0,  1, 0, 'hA,   10, 1, 4);
    tbl[13] = mk(0, 1, 1, 'hC,    12, 0,  0, 1, 0,     0,  0, 5);
    tbl[14] = mk(0, 0, 1, 'hE,    14, 0,  1, 1, 'hE,   14, 1, 5);
    tbl[15] = mk(0, 1, 1, 'hF,    15, 0,  0, 1, 0,     0,  0, 6);
    tbl[16] = mk(0, 0, 0, 0,      0,  1,  0, 1, 0,     0,  0, 6);
    tbl[17] = mk(0, 0, 1, 'h77,   7,  0,  1, 1, 'h77,  7,  1, 6);
    tbl[18] = mk(1, 0, 1, 'h88,   8,  0,  0, 1, 0,     0,  0, 0);

    // ---------------- directed table ----------------
    for (int i = 0; i < 19; i++) begin
      rst     = tbl[i].rst;
      b.wdata = tbl[i].wdata;
      b.wd    = tbl[i].wd;
      b.wreg  = tbl[i].iv;
      b.whilo = (i == 0) ? 1'bx : 1'b0;
      b.hi    = (i == 0) ? 'x : '0;
      b.lo    = (i == 0) ? 'x : '0;
      drive1(tbl[i].flush, tbl[i].iv, b, tbl[i].ordy);
      tick();
      check($sformatf("row%0d_out_valid", i), 64'(bus1.out_valid), 64'(tbl[i].e_ov));
      check($sformatf("row%0d_in_ready", i), 64'(bus1.in_ready), 64'(tbl[i].e_ir));
      check($sformatf("row%0d_out_wdata", i), 64'(bus1.out_wdata), 64'(tbl[i].e_wdata));
      check($sformatf("row%0d_out_wd", i), 64'(bus1.out_wd), 64'(tbl[i].e_wd));
      check($sformatf("row%0d_out_wreg", i), 64'(bus1.out_wreg), 64'(tbl[i].e_wreg));
      check($sformatf("row%0d_stall_cnt", i), 64'(cnt1), 64'(tbl[i].e_cnt));
    end

    // ---------------- HI/LO carried with HILO_EN=1 ----------------
    rst = 1'b0;
    b = '{wdata: 32'h5, wd: 5'd5, wreg: 1'b1, whilo: 1'b1, hi: 32'hDEAD, lo: 32'hBEEF};
    drive1(1'b0, 1'b1, b, 1'b1);
    tick();
    check("hilo_out_valid", 64'(bus1.out_valid), 64'd1);
    check("hilo_out_whilo", 64'(bus1.out_whilo), 64'd1);
    check("hilo_out_hi", 64'(bus1.out_hi), 64'hDEAD);
    check("hilo_out_lo", 64'(bus1.out_lo), 64'hBEEF);
    drive1(1'b0, 1'b0, zero_b, 1'b1);
    tick();
    check("hilo_bubble_whilo", 64'(bus1.out_whilo), 64'd0);
    check("hilo_bubble_hold_hi", 64'(bus1.out_hi), 64'hDEAD);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // ---------------- randomized run against queue model ----------------
    exp_q.delete();
    last = '0;
    mcnt = 0;
    for (int c = 0; c < 600; c++) begin
      logic r, f, iv, ordy, acc, drn;
      int sz;
      r    = ($urandom_range(0, 99) == 0);
      f    = ($urandom_range(0, 19) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      b.wdata = $urandom;
      b.wd    = 5'($urandom_range(0, 31));
      b.wreg  = 1'($urandom_range(0, 1));
      b.whilo = 1'($urandom_range(0, 1));
      b.hi    = $urandom;
      b.lo    = $urandom;
      rst = r;
      drive1(f, iv, b, ordy);
      sz  = exp_q.size();
      acc = iv && (sz < 2);
      drn = (sz > 0) && ordy;
      tick();
      if (r) begin
        exp_q.delete();
        last = '0;
        mcnt = 0;
      end else begin
        if (sz > 0 && !ordy && mcnt < 65535) mcnt++;
        if (f) begin
          exp_q.delete();
          last = '0;
        end else begin
          if (drn) void'(exp_q.pop_front());
          if (acc) exp_q.push_back(b);
        end
        if (exp_q.size() > 0) last = exp_q[0];
      end
      check("rnd_out_valid", 64'(bus1.out_valid), 64'(exp_q.size() > 0));
      check("rnd_in_ready", 64'(bus1.in_ready), 64'(exp_q.size() < 2));
      check("rnd_out_wdata", 64'(bus1.out_wdata), 64'(last.wdata));
      check("rnd_out_wd", 64'(bus1.out_wd), 64'(last.wd));
      check("rnd_out_wreg", 64'(bus1.out_wreg), 64'((exp_q.size() > 0) && last.wreg));
      check("rnd_out_whilo", 64'(bus1.out_whilo), 64'((exp_q.size() > 0) && last.whilo));
      check("rnd_out_hi", 64'(bus1.out_hi), 64'(last.hi));
      check("rnd_out_lo", 64'(bus1.out_lo), 64'(last.lo));
      check("rnd_stall_cnt", 64'(cnt1), 64'(mcnt));
    end
    rst = 1'b0;
    drive1(1'b0, 1'b0, zero_b, 1'b1);

    // ---------------- HILO_EN=0 and CNT_W=4 saturation ----------------
    b = '{wdata: 32'h55, wd: 5'd9, wreg: 1'b1, whilo: 1'b1, hi: 32'hDEAD, lo: 32'hBEEF};
    drive2(1'b1, b, 1'b0);
    tick();
    check("nohilo_out_valid", 64'(bus2.out_valid), 64'd1);
    check("nohilo_out_wreg", 64'(bus2.out_wreg), 64'd1);
    check("nohilo_out_wdata", 64'(bus2.out_wdata), 64'h55);
    check("nohilo_out_whilo", 64'(bus2.out_whilo), 64'd0);
    check("nohilo_out_hi", 64'(bus2.out_hi), 64'd0);
    check("nohilo_out_lo", 64'(bus2.out_lo), 64'd0);
    check("sat_start", 64'(cnt2), 64'd0);
    drive2(1'b0, zero_b, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("sat_cnt_k%0d", k), 64'(cnt2), 64'((k < 15) ? k : 15));
    end
    drive2(1'b0, zero_b, 1'b1);
    tick();
    check("sat_drain_out_valid", 64'(bus2.out_valid), 64'd0);
    check("sat_hold_after_drain", 64'(cnt2), 64'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
